duck_score_keeper: RTL and testbench

//  Synchronous bookkeeping stage downstream of the movement/firing FSMs: consumes the per-bird

---
 rtl/duck_score_keeper.sv | 155 +++++++++++++++
 tb/tb_duck_score_keeper.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/duck_score_keeper.sv
// Duck-hunt score keeper: edge-detects bird resolution events, tallies hits/escapes, keeps a saturating BCD score and round/game-over state.
// Latency 3+HIT_TENS (hit) or 3+MISS_TENS (escape) cycles from event to idle; events arriving while busy are dropped, not queued.
module duck_score_keeper #(
  parameter int BIRDS_PER_ROUND = 10,
  parameter int HIT_TENS        = 5,
  parameter int MISS_TENS       = 1,
  parameter int MAX_ROUND       = 9
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       leave,
  input  logic       escape,
  input  logic       is_shot,
  output logic [9:0] birds,
  output logic [3:0] birds_hit,
  output logic [3:0] birds_lost,
  output logic [3:0] round,
  output logic       game_over,
  output logic [3:0] score_tens,
  output logic [3:0] score_hundreds,
  output logic [3:0] score_thousands,
  output logic       round_done,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TALLY = 3'd1;
  localparam logic [2:0] S_SCORE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic [2:0] state;
  logic       leave_q;
  logic       esc_l;
  logic       hit_l;
  logic [3:0] step;
  logic       event_p;
  logic [3:0] slot;
  logic       at_max;
  logic       at_min;
  logic [3:0] nxt_te;
  logic [3:0] nxt_hu;
  logic [3:0] nxt_th;

  assign event_p = leave & ~leave_q;
  assign slot    = birds_hit + birds_lost;
  assign busy    = (state != S_IDLE) && (state != S_OVER);
  assign at_max  = {score_thousands, score_hundreds, score_tens} == 12'h999;
  assign at_min  = {score_thousands, score_hundreds, score_tens} == 12'h000;

  // One BCD step towards the hit/escape direction, clamped at 999 and 000.
  always_comb begin
    nxt_te = score_tens;
    nxt_hu = score_hundreds;
    nxt_th = score_thousands;
    if (hit_l) begin
      if (!at_max) begin
        if (score_tens == 4'd9) begin
          nxt_te = 4'd0;
          if (score_hundreds == 4'd9) begin
            nxt_hu = 4'd0;
            nxt_th = score_thousands + 4'd1;
          end else begin
            nxt_hu = score_hundreds + 4'd1;
          end
        end else begin
          nxt_te = score_tens + 4'd1;
        end
      end
    end else if (!at_min) begin
      if (score_tens == 4'd0) begin
        nxt_te = 4'd9;
        if (score_hundreds == 4'd0) begin
          nxt_hu = 4'd9;
          nxt_th = score_thousands - 4'd1;
        end else begin
          nxt_hu = score_hundreds - 4'd1;
        end
      end else begin
        nxt_te = score_tens - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      leave_q         <= 1'b0;
      esc_l           <= 1'b0;
      hit_l           <= 1'b0;
      step            <= 4'd0;
      birds           <= 10'h3FF;
      birds_hit       <= 4'd0;
      birds_lost      <= 4'd0;
      round           <= 4'd0;
      game_over       <= 1'b0;
      score_tens      <= 4'd0;
      score_hundreds  <= 4'd0;
      score_thousands <= 4'd0;
      round_done      <= 1'b0;
    end else begin
      leave_q    <= leave;
      round_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (event_p && (escape || is_shot)) begin
            esc_l <= escape;
            hit_l <= is_shot & ~escape;
            step  <= escape ? 4'(MISS_TENS) : 4'(HIT_TENS);
            state <= S_TALLY;
          end
        end
        S_TALLY: begin
          if (hit_l) begin
            birds[slot] <= 1'b0;
            birds_hit   <= birds_hit + 4'd1;
          end else if (esc_l) begin
            birds_lost  <= birds_lost + 4'd1;
          end
          state <= S_SCORE;
        end
        S_SCORE: begin
          if (step != 4'd0) begin
            score_tens      <= nxt_te;
            score_hundreds  <= nxt_hu;
            score_thousands <= nxt_th;
            step            <= step - 4'd1;
          end
          // Leaving on the last step keeps the total at 3 + step count.
          if (step <= 4'd1) state <= S_CHECK;
        end
        S_CHECK: begin
          if (slot == 4'(BIRDS_PER_ROUND)) begin
            if (birds_hit >= birds_lost) begin
              birds      <= 10'h3FF;
              birds_hit  <= 4'd0;
              birds_lost <= 4'd0;
              if (round != 4'(MAX_ROUND)) round <= round + 4'd1;
              round_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              game_over <= 1'b1;
              state     <= S_OVER;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_OVER:  state <= S_OVER;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_duck_score_keeper.sv
// Directed bench for duck_score_keeper: vector table of single events plus hand sequences for saturation, drops and reset.
module tb_duck_score_keeper;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       leave = 1'b0;
  logic       escape = 1'b0;
  logic       is_shot = 1'b0;
  logic [9:0] birds;
  logic [3:0] birds_hit, birds_lost, round;
  logic       game_over;
  logic [3:0] score_tens, score_hundreds, score_thousands;
  logic       round_done, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  duck_score_keeper dut (
    .clk(clk), .resetn(resetn), .leave(leave), .escape(escape), .is_shot(is_shot),
    .birds(birds), .birds_hit(birds_hit), .birds_lost(birds_lost), .round(round),
    .game_over(game_over), .score_tens(score_tens), .score_hundreds(score_hundreds),
    .score_thousands(score_thousands), .round_done(round_done), .busy(busy)
  );

  typedef struct {
    logic        rst;
    logic        esc;
    logic        shot;
    int          lat;
    logic [9:0]  birds;
    logic [3:0]  hit;
    logic [3:0]  lost;
    logic [11:0] score;
    logic [3:0]  round;
    logic        go;
    logic        rd;
  } vec_t;

  vec_t tv[23];

  function automatic vec_t mk(logic rst, logic esc, logic shot, int lat, logic [9:0] b,
                              logic [3:0] h, logic [3:0] l, logic [11:0] s,
                              logic [3:0] r, logic go, logic rd);
    vec_t v;
    v.rst = rst; v.esc = esc; v.shot = shot; v.lat = lat; v.birds = b;
    v.hit = h; v.lost = l; v.score = s; v.round = r; v.go = go; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [9:0] b, input logic [3:0] h,
                             input logic [3:0] l, input logic [11:0] s, input logic [3:0] r,
                             input logic go);
    check({name, ".birds"}, int'(birds), int'(b));
    check({name, ".hit"},   int'(birds_hit), int'(h));
    check({name, ".lost"},  int'(birds_lost), int'(l));
    check({name, ".score"}, int'({score_thousands, score_hundreds, score_tens}), int'(s));
    check({name, ".round"}, int'(round), int'(r));
    check({name, ".go"},    int'(game_over), int'(go));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Pulse leave for one cycle and wait for the DUT to return to idle.
  task automatic fire(input logic e, input logic s, output int lat, output logic rd);
    int n;
    @(negedge clk);
    leave = 1'b1; escape = e; is_shot = s;
    @(negedge clk);
    leave = 1'b0; escape = 1'b0; is_shot = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL fire_timeout: busy still high after %0d cycles, expected idle", n);
    end
    rd  = round_done;
    lat = (n == 0) ? 0 : n + 1;
  endtask

  initial begin
    int   lat;
    logic rd;

    // {rst, esc, shot, latency, birds, hit, lost, score, round, game_over, round_done}
    tv[0]  = mk(1, 1, 1, 4, 10'h3FF, 0, 1, 12'h000, 0, 0, 0);
    tv[1]  = mk(1, 0, 0, 0, 10'h3FF, 0, 0, 12'h000, 0, 0, 0);
    tv[2]  = mk(1, 0, 1, 8, 10'h3FE, 1, 0, 12'h005, 0, 0, 0);
    tv[3]  = mk(0, 0, 1, 8, 10'h3FC, 2, 0, 12'h010, 0, 0, 0);
    tv[4]  = mk(0, 1, 0, 4, 10'h3FC, 2, 1, 12'h009, 0, 0, 0);
    tv[5]  = mk(0, 0, 1, 8, 10'h3F4, 3, 1, 12'h014, 0, 0, 0);
    tv[6]  = mk(0, 1, 0, 4, 10'h3F4, 3, 2, 12'h013, 0, 0, 0);
    tv[7]  = mk(0, 0, 1, 8, 10'h3D4, 4, 2, 12'h018, 0, 0, 0);
    tv[8]  = mk(0, 1, 0, 4, 10'h3D4, 4, 3, 12'h017, 0, 0, 0);
    tv[9]  = mk(0, 0, 1, 8, 10'h354, 5, 3, 12'h022, 0, 0, 0);
    tv[10] = mk(0, 1, 0, 4, 10'h354, 5, 4, 12'h021, 0, 0, 0);
    tv[11] = mk(0, 0, 1, 8, 10'h3FF, 0, 0, 12'h026, 1, 0, 1);
    tv[12] = mk(1, 0, 1, 8, 10'h3FE, 1, 0, 12'h005, 0, 0, 0);
    tv[13] = mk(0, 0, 1, 8, 10'h3FC, 2, 0, 12'h010, 0, 0, 0);
    tv[14] = mk(0, 0, 1, 8, 10'h3F8, 3, 0, 12'h015, 0, 0, 0);
    tv[15] = mk(0, 0, 1, 8, 10'h3F0, 4, 0, 12'h020, 0, 0, 0);
    tv[16] = mk(0, 1, 0, 4, 10'h3F0, 4, 1, 12'h019, 0, 0, 0);
    tv[17] = mk(0, 1, 0, 4, 10'h3F0, 4, 2, 12'h018, 0, 0, 0);
    tv[18] = mk(0, 1, 0, 4, 10'h3F0, 4, 3, 12'h017, 0, 0, 0);
    tv[19] = mk(0, 1, 0, 4, 10'h3F0, 4, 4, 12'h016, 0, 0, 0);
    tv[20] = mk(0, 1, 0, 4, 10'h3F0, 4, 5, 12'h015, 0, 0, 0);
    tv[21] = mk(0, 1, 0, 4, 10'h3F0, 4, 6, 12'h014, 0, 1, 0);
    tv[22] = mk(0, 0, 1, 0, 10'h3F0, 4, 6, 12'h014, 0, 1, 0);

    do_reset();
    check_state("reset", 10'h3FF, 0, 0, 12'h000, 0, 0);
    check("reset.busy", int'(busy), 0);
    check("reset.rd", int'(round_done), 0);

    for (int i = 0; i < 23; i++) begin
      if (tv[i].rst) do_reset();
      fire(tv[i].esc, tv[i].shot, lat, rd);
      check($sformatf("v%0d.lat", i), lat, tv[i].lat);
      check($sformatf("v%0d.rd", i), int'(rd), int'(tv[i].rd));
      check_state($sformatf("v%0d", i), tv[i].birds, tv[i].hit, tv[i].lost,
                  tv[i].score, tv[i].round, tv[i].go);
    end

    // Score saturation: 198 hits reach 990, then 995, then clamp at 999.
    do_reset();
    for (int i = 0; i < 198; i++) fire(1'b0, 1'b1, lat, rd);
    check_state("sat198", 10'h300, 8, 0, 12'h990, 9, 0);
    fire(1'b0, 1'b1, lat, rd);
    check("sat199.score", int'({score_thousands, score_hundreds, score_tens}), 'h995);
    fire(1'b0, 1'b1, lat, rd);
    check_state("sat200", 10'h3FF, 0, 0, 12'h999, 9, 0);
    check("sat200.rd", int'(rd), 1);
    fire(1'b0, 1'b1, lat, rd);
    check("sat201.score", int'({score_thousands, score_hundreds, score_tens}), 'h999);

    // A second leave edge two cycles into a hit is dropped.
    do_reset();
    @(negedge clk); leave = 1'b1; is_shot = 1'b1;
    @(negedge clk); leave = 1'b0;
    @(negedge clk); leave = 1'b1;
    @(negedge clk); leave = 1'b0; is_shot = 1'b0;
    repeat (12) @(negedge clk);
    check_state("drop", 10'h3FE, 1, 0, 12'h005, 0, 0);
    check("drop.busy", int'(busy), 0);

    // Reset asserted while in SCORE aborts at once.
    @(negedge clk); leave = 1'b1; is_shot = 1'b1;
    @(negedge clk); leave = 1'b0; is_shot = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst.busy_before", int'(busy), 1);
    resetn = 1'b0;
    #1;
    check_state("midrst.async", 10'h3FF, 0, 0, 12'h000, 0, 0);
    check("midrst.busy", int'(busy), 0);
    @(negedge clk); resetn = 1'b1;
    repeat (10) @(negedge clk);
    check_state("midrst.after", 10'h3FF, 0, 0, 12'h000, 0, 0);
    check("midrst.busy_after", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
